// File: rtl/cipher_frame_tx_if.sv
// -----------------------------------------------------------------------------
// cipher_frame_tx_if
//
// Byte handshake between the stream cipher (master) and the transmit framer
// (slave). A byte moves on a rising edge where in_valid && in_ready.
//
//   in_data  [7:0]  encrypted byte, driven by the cipher
//   in_valid        in_data is valid this cycle, driven by the cipher
//   in_ready        framer can accept a byte, driven by the framer
// -----------------------------------------------------------------------------
interface cipher_frame_tx_if;
  logic [7:0] in_data;
  logic       in_valid;
  logic       in_ready;

  modport master (
    output in_data,
    output in_valid,
    input  in_ready
  );

  modport slave (
    input  in_data,
    input  in_valid,
    output in_ready
  );
endinterface

// File: rtl/cipher_frame_tx.sv
// -----------------------------------------------------------------------------
// cipher_frame_tx
//
// Transmit framer downstream of the stream cipher. Encrypted bytes are taken
// over a valid/ready handshake into a small FIFO and then serialized onto one
// wire as asynchronous-serial frames:
//   start (0), 8 data bits LSB first, optional even parity, stop (1).
// Each serial bit is held for CLKS_PER_BIT clocks. When another byte is
// waiting at the end of a stop bit the next start bit follows with no gap.
//
// Parameters
//   FIFO_DEPTH    byte buffer entries, power of two, 2..16
//   CLKS_PER_BIT  clocks per serial bit, >= 1
//   PARITY_EN     1 inserts an even-parity bit after the data bits
//
// Ports
//   clk          single clock, rising edge
//   reset        asynchronous, active-low; aborts any frame and empties FIFO
//   in_bus       slave side of the cipher byte handshake
//   tx_serial    registered serial line, idles high
//   tx_busy      registered, high whenever a frame is in progress
//   fifo_level   bytes currently buffered
//   frame_count  frames fully sent since reset, wraps 255 -> 0
// -----------------------------------------------------------------------------
module cipher_frame_tx #(
  parameter int FIFO_DEPTH   = 4,
  parameter int CLKS_PER_BIT = 4,
  parameter bit PARITY_EN    = 1'b1
) (
  input  logic                        clk,
  input  logic                        reset,
  cipher_frame_tx_if.slave            in_bus,
  output logic                        tx_serial,
  output logic                        tx_busy,
  output logic [$clog2(FIFO_DEPTH):0] fifo_level,
  output logic [7:0]                  frame_count
);

  localparam int PW = $clog2(FIFO_DEPTH);
  localparam int LW = PW + 1;
  localparam int TW = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;

  localparam logic [TW-1:0] T_LAST   = TW'(CLKS_PER_BIT - 1);
  localparam logic [LW-1:0] FULL_LVL = LW'(FIFO_DEPTH);

  typedef enum logic [2:0] {
    S_IDLE,
    S_START,
    S_DATA,
    S_PARITY,
    S_STOP
  } state_t;

  // ---------------------------------------------------------------------------
  // FIFO storage and bookkeeping
  // ---------------------------------------------------------------------------
  logic [7:0]    mem [FIFO_DEPTH];
  logic [PW-1:0] wr_ptr;
  logic [PW-1:0] rd_ptr;
  logic [7:0]    head;

  // ---------------------------------------------------------------------------
  // Serializer state
  // ---------------------------------------------------------------------------
  state_t        state;
  logic [7:0]    shift_reg;
  logic          parity_bit;
  logic [2:0]    bit_idx;
  logic [TW-1:0] bit_timer;

  logic push;
  logic pop;
  logic bit_end;

  // Ready looks only at the registered level, so a full FIFO refuses a byte
  // even in a cycle where the serializer is about to pop.
  assign in_bus.in_ready = (fifo_level != FULL_LVL);
  assign push            = in_bus.in_valid && in_bus.in_ready;
  assign head            = mem[rd_ptr];

  // Last clock of the current serial bit. Meaningless in IDLE, where the
  // timer is not consulted.
  assign bit_end = (bit_timer == T_LAST);

  // A byte leaves the FIFO when the line is idle, or at the final clock of a
  // stop bit so the next start bit follows immediately.
  assign pop = (fifo_level != '0) &&
               ((state == S_IDLE) || ((state == S_STOP) && bit_end));

  // NOTE: the byte array carries no reset; the pointers and level define which
  // entries are valid, so clearing the storage itself buys nothing.
  always_ff @(posedge clk) begin
    if (push) begin
      mem[wr_ptr] <= in_bus.in_data;
    end
  end

  // NOTE: all sequential state uses non-blocking assignments so every register
  // samples the pre-edge values of the others, independent of statement order.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      fifo_level <= '0;
    end else begin
      // Power-of-two depth: pointers wrap by natural overflow.
      if (push) begin
        wr_ptr <= wr_ptr + PW'(1);
      end
      if (pop) begin
        rd_ptr <= rd_ptr + PW'(1);
      end
      case ({push, pop})
        2'b10:   fifo_level <= fifo_level + LW'(1);
        2'b01:   fifo_level <= fifo_level - LW'(1);
        default: fifo_level <= fifo_level;
      endcase
    end
  end

  // ---------------------------------------------------------------------------
  // Frame FSM. tx_serial and tx_busy are registered alongside the state so the
  // line never glitches; each non-idle state lasts CLKS_PER_BIT clocks.
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state       <= S_IDLE;
      tx_serial   <= 1'b1;
      tx_busy     <= 1'b0;
      shift_reg   <= '0;
      parity_bit  <= 1'b0;
      bit_idx     <= '0;
      bit_timer   <= '0;
      frame_count <= '0;
    end else begin
      if ((state == S_STOP) && bit_end) begin
        frame_count <= frame_count + 8'd1;
      end

      if (pop) begin
        // Covers both leaving IDLE and chaining straight out of STOP.
        state      <= S_START;
        tx_serial  <= 1'b0;
        tx_busy    <= 1'b1;
        shift_reg  <= head;
        parity_bit <= ^head;
        bit_timer  <= '0;
      end else begin
        case (state)
          S_IDLE: begin
            tx_serial <= 1'b1;
            tx_busy   <= 1'b0;
          end

          S_START: begin
            if (bit_end) begin
              state     <= S_DATA;
              tx_serial <= shift_reg[0];
              bit_idx   <= '0;
              bit_timer <= '0;
            end else begin
              bit_timer <= bit_timer + TW'(1);
            end
          end

          S_DATA: begin
            if (bit_end) begin
              bit_timer <= '0;
              if (bit_idx == 3'd7) begin
                if (PARITY_EN) begin
                  state     <= S_PARITY;
                  tx_serial <= parity_bit;
                end else begin
                  state     <= S_STOP;
                  tx_serial <= 1'b1;
                end
              end else begin
                // Next bit is shift_reg[1] before the shift lands.
                shift_reg <= shift_reg >> 1;
                tx_serial <= shift_reg[1];
                bit_idx   <= bit_idx + 3'd1;
              end
            end else begin
              bit_timer <= bit_timer + TW'(1);
            end
          end

          S_PARITY: begin
            if (bit_end) begin
              state     <= S_STOP;
              tx_serial <= 1'b1;
              bit_timer <= '0;
            end else begin
              bit_timer <= bit_timer + TW'(1);
            end
          end

          S_STOP: begin
            if (bit_end) begin
              // Nothing buffered, otherwise pop would have taken this edge.
              state     <= S_IDLE;
              tx_serial <= 1'b1;
              tx_busy   <= 1'b0;
              bit_timer <= '0;
            end else begin
              bit_timer <= bit_timer + TW'(1);
            end
          end

          default: begin
            state     <= S_IDLE;
            tx_serial <= 1'b1;
            tx_busy   <= 1'b0;
            bit_timer <= '0;
          end
        endcase
      end
    end
  end

endmodule
